// File: rtl/calc_op_driver_pkg.sv
// Shared definitions for the calculator operand driver: FSM states and default widths.
package calc_op_driver_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_OP_W   = 2;
  localparam int DEF_RES_W  = 5;
  localparam int TIMER_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BEAT_A = 3'd1,
    ST_BEAT_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/calc_op_driver_op_timeout_timer.sv
// Loadable 8-bit up-counter; expire flags the last allowed WAIT cycle.
module op_timeout_timer
  import calc_op_driver_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic expire
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/calc_op_driver.sv
// Drives one calculator operation per host request: two capture beats, a bounded
// wait for the result strobe, then a held response until the host takes it.
module calc_op_driver
  import calc_op_driver_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [OP_W-1:0]   req_op,
  output logic              capture,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] d_in,
  input  logic              valid,
  input  logic [RES_W-1:0]  result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_timeout,
  output logic [CNT_W-1:0]  op_count,
  output logic              proto_err
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]    opc_q, opc_d;
  logic               req_ready_q, req_ready_d;
  logic               capture_q, capture_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [DATA_W-1:0]  d_in_q, d_in_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;
  logic               proto_err_q, proto_err_d;
  logic               timer_load, timer_inc, timer_expire;

  assign timer_load = (state_q == ST_BEAT_B);
  assign timer_inc  = (state_q == ST_WAIT) && !valid;

  op_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .inc    (timer_inc),
    .expire (timer_expire)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    opc_d         = opc_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    op_count_d    = op_count_q;
    proto_err_d   = proto_err_q | (valid && (state_q != ST_WAIT));

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          a_d     = req_a;
          b_d     = req_b;
          opc_d   = req_op;
          state_d = ST_BEAT_A;
        end
      end
      ST_BEAT_A: state_d = ST_BEAT_B;
      ST_BEAT_B: state_d = ST_WAIT;
      ST_WAIT: begin
        // A result arriving on the expiry cycle still counts as success.
        if (valid) begin
          rsp_result_d  = result;
          rsp_timeout_d = 1'b0;
          op_count_d    = op_count_q + 1'b1;
          state_d       = ST_RESP;
        end else if (timer_expire) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are flop-driven.
    req_ready_d = (state_d == ST_IDLE);
    capture_d   = (state_d == ST_BEAT_A) || (state_d == ST_BEAT_B);
    op_d        = capture_d ? opc_d : '0;
    d_in_d      = (state_d == ST_BEAT_A) ? a_d :
                  (state_d == ST_BEAT_B) ? b_d : '0;
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      opc_q         <= '0;
      req_ready_q   <= 1'b1;
      capture_q     <= 1'b0;
      op_q          <= '0;
      d_in_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      op_count_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      opc_q         <= opc_d;
      req_ready_q   <= req_ready_d;
      capture_q     <= capture_d;
      op_q          <= op_d;
      d_in_q        <= d_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      op_count_q    <= op_count_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign capture     = capture_q;
  assign op          = op_q;
  assign d_in        = d_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign op_count    = op_count_q;
  assign proto_err   = proto_err_q;

endmodule
